// File: rtl/pipelined_addsub_pkg.sv
// Shared defaults and elaboration helpers for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

    localparam int DEF_WIDTH            = 64;
    localparam int DEF_CHUNK            = 8;
    localparam int DEF_CHUNKS_PER_STAGE = 2;

    // Number of pipeline stages; each stage covers chunk*cps result bits.
    function automatic int calc_nstage(input int width, input int chunk, input int cps);
        return width / (chunk * cps);
    endfunction

    // A configuration is usable only if the width splits evenly into whole stages.
    function automatic bit cfg_legal(input int width, input int chunk, input int cps);
        if (chunk < 1 || cps < 1) begin
            return 1'b0;
        end
        return ((width % (chunk * cps)) == 0) && ((width / (chunk * cps)) >= 1);
    endfunction

endpackage

// File: rtl/pipelined_addsub_stage.sv
// One combinational pipeline slice: CHUNKS carry-lookahead blocks of CHUNK bits.
// Reports the slice sum, carry out, carry into the slice MSB and slice-is-zero.
module addsub_stage
    import pipelined_addsub_pkg::*;
#(
    parameter int  CHUNK  = DEF_CHUNK,
    parameter int  CHUNKS = DEF_CHUNKS_PER_STAGE,
    localparam int SW     = CHUNK * CHUNKS
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb,
    output logic          zero
);

    // Two-level lookahead: bit carries come from the running group generate /
    // propagate of the chunk, chunk carries from each chunk's group terms.
    always_comb begin
        logic c_chunk;
        logic gg;
        logic pp;
        logic c_bit;
        sum     = '0;
        c_chunk = cin;
        gg      = 1'b0;
        pp      = 1'b1;
        c_bit   = 1'b0;
        for (int j = 0; j < CHUNKS; j++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < CHUNK; i++) begin
                c_bit = gg | (pp & c_chunk);
                sum[j*CHUNK+i] = a[j*CHUNK+i] ^ b[j*CHUNK+i] ^ c_bit;
                gg = (a[j*CHUNK+i] & b[j*CHUNK+i]) | ((a[j*CHUNK+i] ^ b[j*CHUNK+i]) & gg);
                pp = pp & (a[j*CHUNK+i] ^ b[j*CHUNK+i]);
            end
            c_chunk = gg | (pp & c_chunk);
        end
        // c_bit was last computed for the slice MSB
        cmsb = c_bit;
        cout = c_chunk;
    end

    assign zero = (sum == '0);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
// The carry chain is cut between stages; operand slices are skewed in and
// result slices de-skewed out so the whole word and its flags align.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int CHUNK            = DEF_CHUNK,
    parameter int CHUNKS_PER_STAGE = DEF_CHUNKS_PER_STAGE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW     = CHUNK * CHUNKS_PER_STAGE;
    localparam int NSTAGE = calc_nstage(WIDTH, CHUNK, CHUNKS_PER_STAGE);

    if (!cfg_legal(WIDTH, CHUNK, CHUNKS_PER_STAGE)) begin : g_bad_cfg
        $fatal(1, "pipelined_addsub: WIDTH must be a positive multiple of CHUNK*CHUNKS_PER_STAGE");
    end

    logic              advance;
    logic [WIDTH-1:0]  b_eff;
    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] carry_q;
    logic [NSTAGE-1:0] zacc_q;
    logic              ovf_q;

    // Subtraction is A + ~B + 1; the +1 enters as the stage-0 carry-in.
    assign b_eff     = b ^ {WIDTH{sub}};
    assign out_valid = valid_q[NSTAGE-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign cout      = carry_q[NSTAGE-1];
    assign zero      = zacc_q[NSTAGE-1];
    assign neg       = s[WIDTH-1];
    assign ovf       = ovf_q;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [SW-1:0] st_a;
        logic [SW-1:0] st_b;
        logic [SW-1:0] st_sum;
        logic          st_cin;
        logic          st_cout;
        logic          st_cmsb;
        logic          st_zero;
        logic          vld_prev;
        logic          zacc_prev;
        logic          vld_r;
        logic          cy_r;
        logic          zacc_r;
        logic [SW-1:0] res_q [NSTAGE-k];

        if (k == 0) begin : g_head
            assign st_a      = a[SW-1:0];
            assign st_b      = b_eff[SW-1:0];
            assign st_cin    = sub;
            assign vld_prev  = in_valid;
            assign zacc_prev = 1'b1;
        end else begin : g_skew
            logic [SW-1:0] a_sk [k];
            logic [SW-1:0] b_sk [k];

            // Operand skew: slice k reaches its adder k cycles after acceptance.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < k; j++) begin
                        a_sk[j] <= '0;
                        b_sk[j] <= '0;
                    end
                end else if (advance) begin
                    a_sk[0] <= a[k*SW +: SW];
                    b_sk[0] <= b_eff[k*SW +: SW];
                    for (int j = 1; j < k; j++) begin
                        a_sk[j] <= a_sk[j-1];
                        b_sk[j] <= b_sk[j-1];
                    end
                end
            end

            assign st_a      = a_sk[k-1];
            assign st_b      = b_sk[k-1];
            assign st_cin    = carry_q[k-1];
            assign vld_prev  = valid_q[k-1];
            assign zacc_prev = zacc_q[k-1];
        end

        addsub_stage #(
            .CHUNK  (CHUNK),
            .CHUNKS (CHUNKS_PER_STAGE)
        ) u_stage (
            .a    (st_a),
            .b    (st_b),
            .cin  (st_cin),
            .sum  (st_sum),
            .cout (st_cout),
            .cmsb (st_cmsb),
            .zero (st_zero)
        );

        // Per-level valid bit, carry handed to the next stage, running zero flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r  <= 1'b0;
                cy_r   <= 1'b0;
                zacc_r <= 1'b0;
            end else if (advance) begin
                vld_r  <= vld_prev;
                cy_r   <= st_cout;
                zacc_r <= zacc_prev & st_zero;
            end
        end

        assign valid_q[k] = vld_r;
        assign carry_q[k] = cy_r;
        assign zacc_q[k]  = zacc_r;

        // Result de-skew: early slices wait so every slice leaves together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < NSTAGE - k; j++) begin
                    res_q[j] <= '0;
                end
            end else if (advance) begin
                res_q[0] <= st_sum;
                for (int j = 1; j < NSTAGE - k; j++) begin
                    res_q[j] <= res_q[j-1];
                end
            end
        end

        assign s[k*SW +: SW] = res_q[NSTAGE-k-1];

        if (k == NSTAGE - 1) begin : g_tail
            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= st_cout ^ st_cmsb;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub at default parameters (64 bit, 4 stages).
module tb_pipelined_addsub;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    logic held   = 1'b0;
    res_t held_r;

    pipelined_addsub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb_sub);
        logic [W:0]   full;
        logic [W-1:0] yy;
        res_t         r;
        yy     = sb_sub ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sb_sub};
        r.s    = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
        r.zero = (r.s == '0);
        r.neg  = r.s[W-1];
        return r;
    endfunction

    // Scoreboard consumer and output-hold check, sampled mid-cycle.
    always @(negedge clk) begin
        res_t got;
        res_t exp;
        got = {s, cout, ovf, zero, neg};
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!out_valid || got !== held_r) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b res=%h, want valid=1 res=%h", out_valid, got, held_r);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got res=%h, want no output", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL scoreboard: got res=%h, want %h", got, exp);
                    end
                end
                n_out++;
            end
            held   = out_valid && !out_ready;
            held_r = got;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        #2;
        checks++;
        if ({out_valid, s, cout, ovf, zero, neg} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_during: got v=%0b s=%h c=%0b o=%0b z=%0b n=%0b rdy=%0b, want all 0 rdy=1",
                     out_valid, s, cout, ovf, zero, neg, in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: got v=%0b rdy=%0b, want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    // One isolated operation: checks latency and the flags against fixed values.
    task automatic run_directed(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                input logic xs, input logic [W-1:0] es, input logic ec,
                                input logic eo, input logic ez, input logic en);
        int lat;
        int w;
        @(posedge clk);
        #1;
        a         = xa;
        b         = xb;
        sub       = xs;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s_accept: got in_ready=0, want 1", name);
        end
        sb.push_back(model(xa, xb, xs));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges after accept, want 3", name, lat);
        end
        checks++;
        if ({s, cout, ovf, zero, neg} !== {es, ec, eo, ez, en}) begin
            errors++;
            $display("FAIL %s_result: got s=%h c=%0b o=%0b z=%0b n=%0b, want s=%h c=%0b o=%0b z=%0b n=%0b",
                     name, s, cout, ovf, zero, neg, es, ec, eo, ez, en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_basic;
        run_directed("add_5_3", 64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sub;
        run_directed("sub_3_3", 64'd3, 64'd3, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_directed("sub_3_5", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_carry_chain;
        run_directed("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow;
        run_directed("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000,
                     1'b0, 1'b1, 1'b0, 1'b1);
        run_directed("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
                     1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int           sent;
        int           cyc;
        int           base;
        int           dr;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        base = n_out;
        sent = 0;
        cyc  = 0;
        ra   = {$urandom, $urandom};
        rb   = {$urandom, $urandom};
        rs   = 1'($urandom_range(0, 1));
        while (sent < 16 && cyc < 200) begin
            @(posedge clk);
            #1;
            out_ready = !(cyc >= 8 && cyc <= 10);
            in_valid  = !(cyc == 3 || cyc == 12 || cyc == 13);
            a         = ra;
            b         = rb;
            sub       = rs;
            @(negedge clk);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready: got %0b, want %0b (cycle %0d)", in_ready, (!out_valid || out_ready), cyc);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(ra, rb, rs));
                sent++;
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rs = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        checks++;
        if (sent != 16) begin
            errors++;
            $display("FAIL b2b_send_timeout: got %0d sent, want 16", sent);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dr = 0;
        while (sb.size() > 0 && dr < 50) begin
            @(posedge clk);
            dr++;
        end
        #1;
        checks++;
        if (n_out - base != 16 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs with %0d pending, want 16 and 0", n_out - base, sb.size());
        end
    endtask

    task automatic test_midflight_reset;
        int   w;
        logic seen;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sub       = 1'b0;
        a = 64'h8000_0000_0000_0001; b = 64'h8000_0000_0000_0000;
        @(posedge clk);
        #1 a = 64'd5;  b = 64'd6;
        @(posedge clk);
        #1 a = 64'd11; b = 64'd12;
        @(posedge clk);
        #1 in_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if ({out_valid, s, cout, ovf} !== {1'b1, 64'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL midflight_first: got v=%0b s=%h c=%0b o=%0b, want v=1 s=1 c=1 o=1",
                     out_valid, s, cout, ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({out_valid, s, cout, ovf, zero, neg} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset_outputs: got v=%0b s=%h c=%0b o=%0b z=%0b n=%0b rdy=%0b, want all 0 rdy=1",
                     out_valid, s, cout, ovf, zero, neg, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midflight_discard: got out_valid pulse, want none");
        end
        run_directed("post_reset", 64'd42, 64'd17, 1'b1, 64'd25, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_sub();
        test_carry_chain();
        test_overflow();
        test_back_to_back();
        test_midflight_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
